uart_tx_merge_fifo: RTL

Sits between the dual-issue core's two IO write ports (slot a, slot b) and the single UART emitter. Merges UART data writes from both slots into one byte FIFO. Slot a is always enqueued ahead of slot b, which preserves program order. Drains the FIFO to the emitter over a valid/ready handshake and returns a busy status word that software polls instead of raw emitter readiness.

---
 rtl/uart_io_pkg.sv | 21 ++
 rtl/fifo_2w1r.sv | 61 ++++++
 rtl/uart_tx_merge_fifo.sv | 62 ++++++
 3 files changed

// File: rtl/uart_io_pkg.sv
// Shared UART IO definitions: status word layout, register offsets and byte type.
package uart_io_pkg;

    localparam int STATUS_BUSY_BIT = 9;
    localparam int STATUS_OVF_BIT  = 10;
    localparam int STATUS_CNT_LSB  = 11;
    localparam int STATUS_CNT_W    = 5;

    localparam logic [31:0] UART_DATA_OFS   = 32'h0000_0000;
    localparam logic [31:0] UART_STATUS_OFS = 32'h0000_0004;

    typedef logic [7:0] byte_t;

    // Occupancy as reported in the status word, clamped to the field's range.
    function automatic logic [STATUS_CNT_W-1:0] sat_cnt(input logic [31:0] c);
        if (c > 32'((1 << STATUS_CNT_W) - 1))
            return '1;
        return c[STATUS_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/fifo_2w1r.sv
// Dual-write, single-read byte FIFO with first-word fall-through; slot a is
// always enqueued ahead of slot b.
module fifo_2w1r
    import uart_io_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_wr,
    input  byte_t       a_data,
    input  logic        b_wr,
    input  byte_t       b_data,
    output logic        out_valid,
    output byte_t       out_data,
    input  logic        out_ready,
    output logic [AW:0] count,
    output logic        drop
);

    byte_t       mem [DEPTH];
    logic [AW:0] wp, rp, cnt;
    logic [AW:0] free, n_push, b_idx;
    logic        a_acc, b_acc, pop;

    // Admission sees only the occupancy registered at the start of the cycle.
    always_comb begin
        free   = (AW+1)'(DEPTH) - cnt;
        a_acc  = a_wr && (free != '0);
        b_acc  = b_wr && ((free >= (AW+1)'(2)) || ((free == (AW+1)'(1)) && !a_wr));
        drop   = (a_wr && !a_acc) || (b_wr && !b_acc);
        pop    = out_valid && out_ready;
        n_push = (AW+1)'(a_acc) + (AW+1)'(b_acc);
        b_idx  = wp + (AW+1)'(a_acc);
    end

    // NOTE: storage has no reset; contents are don't-care until written, and
    // keeping reset off the array lets it map to plain flops or RAM.
    always_ff @(posedge clk) begin
        if (a_acc) mem[wp[AW-1:0]]    <= a_data;
        if (b_acc) mem[b_idx[AW-1:0]] <= b_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= wp + n_push;
            rp  <= rp + (AW+1)'(pop);
            cnt <= cnt + n_push - (AW+1)'(pop);
        end
    end

    assign out_valid = (cnt != '0);
    assign out_data  = mem[rp[AW-1:0]];
    assign count     = cnt;

endmodule

// File: rtl/uart_tx_merge_fifo.sv
// Merges both core IO write slots into one UART byte FIFO and exposes the
// busy/overflow/count status word that software polls.
module uart_tx_merge_fifo
    import uart_io_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_wr,
    input  logic [7:0]  a_data,
    input  logic        b_wr,
    input  logic [7:0]  b_data,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic [31:0] status,
    input  logic        ovf_clr,
    output logic [AW:0] count
);

    logic drop;
    logic ovf;
    logic busy;

    fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .a_wr      (a_wr),
        .a_data    (a_data),
        .b_wr      (b_wr),
        .b_data    (b_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .drop      (drop)
    );

    // A new drop outranks a same-cycle clear so no overflow is ever lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf <= 1'b0;
        else if (drop)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end

    // Busy whenever fewer than two slots remain, so "not busy" admits a dual write.
    assign busy = ((AW+1)'(DEPTH) - count) < (AW+1)'(2);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        status                                = '0;
        status[STATUS_BUSY_BIT]               = busy;
        status[STATUS_OVF_BIT]                = ovf;
        status[STATUS_CNT_LSB +: STATUS_CNT_W] = sat_cnt(32'(count));
    end

endmodule
